// File: rtl/multi_box_bouncer.sv
// multi_box_bouncer: N-box bouncing engine for the VGA display path.
// Each frame tick (first cycle with xcounter==0 && ycounter==0 && box_enable)
// starts one sweep that updates one box per clock, box i landing at tick+1+i.
//
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   box_enable          gates frame ticks
//   max_x/max_y         screen dimensions
//   box_width/height    size shared by all boxes
//   xcounter/ycounter   VGA sync counters
//   step_x/step_y       per-box step, box i at [i*STEP_W +: STEP_W]
//   box_x_pos/box_y_pos packed per-box left/top coordinates
//   x_dir/y_dir         per-box direction (x: 0 right, y: 0 down)
//   bounce              one-cycle wall-hit pulse per box
//   busy                high while a sweep runs (N_BOXES cycles)
//   bounce_count        8-bit saturating bounce counters per box, present
//                       only when MULTI_BOX_BOUNCE_COUNT_EN is defined
module multi_box_bouncer #(
    parameter int unsigned N_BOXES = 4,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned STEP_W  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         box_enable,
    input  logic [COORD_W-1:0]           max_x,
    input  logic [COORD_W-1:0]           max_y,
    input  logic [COORD_W-1:0]           box_width,
    input  logic [COORD_W-1:0]           box_height,
    input  logic [COORD_W-1:0]           xcounter,
    input  logic [COORD_W-1:0]           ycounter,
    input  logic [N_BOXES*STEP_W-1:0]    step_x,
    input  logic [N_BOXES*STEP_W-1:0]    step_y,
    output logic [N_BOXES*COORD_W-1:0]   box_x_pos,
    output logic [N_BOXES*COORD_W-1:0]   box_y_pos,
    output logic [N_BOXES-1:0]           x_dir,
    output logic [N_BOXES-1:0]           y_dir,
    output logic [N_BOXES-1:0]           bounce,
    output logic                         busy
`ifdef MULTI_BOX_BOUNCE_COUNT_EN
    ,
    output logic [N_BOXES*8-1:0]         bounce_count
`endif
);

    localparam int unsigned IDX_W = (N_BOXES > 1) ? $clog2(N_BOXES) : 1;
    localparam int unsigned AW    = COORD_W + 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BOXES - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state, next_state;
    logic [IDX_W-1:0]     idx, next_idx;
    logic                 match_q;
    logic                 match_c, tick_c;
    logic                 upd_en_c;
    logic [IDX_W-1:0]     upd_idx_c;
    logic [COORD_W+1:0]   x_res_c, y_res_c;
    logic [COORD_W-1:0]   x_init_c, y_init_c;

    logic [COORD_W-1:0]   pos_x [N_BOXES];
    logic [COORD_W-1:0]   pos_y [N_BOXES];
    logic [STEP_W-1:0]    sx    [N_BOXES];
    logic [STEP_W-1:0]    sy    [N_BOXES];

    // One axis move; returns {bounced, new_dir, new_pos}. Widened so nothing wraps.
    function automatic logic [COORD_W+1:0] axis_step(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [STEP_W-1:0]  s,
        input logic [COORD_W-1:0] size,
        input logic [COORD_W-1:0] lim
    );
        logic [AW-1:0] p, st, sz, lm;
        p  = AW'(pos);
        st = AW'(s);
        sz = AW'(size);
        lm = AW'(lim);
        if (sz >= lm)
            axis_step = {1'b0, 1'b0, COORD_W'(0)};
        else if (!dir) begin
            if (p + sz + st >= lm)
                axis_step = {1'b1, 1'b1, COORD_W'(lm - sz)};
            else
                axis_step = {1'b0, 1'b0, COORD_W'(p + st)};
        end else begin
            if (p <= st)
                axis_step = {1'b1, 1'b0, COORD_W'(0)};
            else
                axis_step = {1'b0, 1'b1, COORD_W'(p - st)};
        end
    endfunction

    // Unpack per-box steps and pack positions onto the output buses.
    for (genvar g = 0; g < N_BOXES; g++) begin : g_box
        assign sx[g] = step_x[g*STEP_W +: STEP_W];
        assign sy[g] = step_y[g*STEP_W +: STEP_W];
        assign box_x_pos[g*COORD_W +: COORD_W] = pos_x[g];
        assign box_y_pos[g*COORD_W +: COORD_W] = pos_y[g];
    end

    // Rising edge of the (0,0) match gives exactly one tick per held origin.
    assign match_c  = (xcounter == '0) && (ycounter == '0) && box_enable;
    assign tick_c   = match_c && !match_q;
    assign x_init_c = (max_x > box_width)  ? COORD_W'((max_x - box_width) >> 1)  : '0;
    assign y_init_c = (max_y > box_height) ? COORD_W'((max_y - box_height) >> 1) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Next-state logic; ticks while sweeping are simply ignored
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            IDLE: begin
                if (tick_c) begin
                    next_state = SWEEP;
                    next_idx   = '0;
                end
            end
            SWEEP: begin
                if (idx == LAST) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else begin
                    next_idx = IDX_W'(idx + 1'b1);
                end
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    // Output/control logic: box `idx` is shown during SWEEP, so the box
    // written at each edge is the one to be shown in the following cycle.
    always_comb begin
        upd_en_c  = 1'b0;
        upd_idx_c = '0;
        if (state == IDLE && tick_c) begin
            upd_en_c = 1'b1;
        end else if (state == SWEEP && idx != LAST) begin
            upd_en_c  = 1'b1;
            upd_idx_c = IDX_W'(idx + 1'b1);
        end
        x_res_c = axis_step(pos_x[upd_idx_c], x_dir[upd_idx_c], sx[upd_idx_c], box_width,  max_x);
        y_res_c = axis_step(pos_y[upd_idx_c], y_dir[upd_idx_c], sy[upd_idx_c], box_height, max_y);
    end

`ifdef MULTI_BOX_BOUNCE_COUNT_EN
    logic [7:0] cnt [N_BOXES];
    for (genvar g = 0; g < N_BOXES; g++) begin : g_cnt
        assign bounce_count[g*8 +: 8] = cnt[g];
    end
`endif

    // Box state, pulses and busy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BOXES; i++) begin
                pos_x[i] <= x_init_c;
                pos_y[i] <= y_init_c;
                x_dir[i] <= i[0];
                y_dir[i] <= i[1];
`ifdef MULTI_BOX_BOUNCE_COUNT_EN
                cnt[i]   <= '0;
`endif
            end
            bounce  <= '0;
            busy    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= match_c;
            busy    <= (next_state == SWEEP);
            bounce  <= '0;
            if (upd_en_c) begin
                pos_x[upd_idx_c]  <= x_res_c[COORD_W-1:0];
                x_dir[upd_idx_c]  <= x_res_c[COORD_W];
                pos_y[upd_idx_c]  <= y_res_c[COORD_W-1:0];
                y_dir[upd_idx_c]  <= y_res_c[COORD_W];
                bounce[upd_idx_c] <= x_res_c[COORD_W+1] | y_res_c[COORD_W+1];
`ifdef MULTI_BOX_BOUNCE_COUNT_EN
                if ((x_res_c[COORD_W+1] | y_res_c[COORD_W+1]) && cnt[upd_idx_c] != 8'hFF)
                    cnt[upd_idx_c] <= cnt[upd_idx_c] + 8'd1;
`endif
            end
        end
    end

endmodule
